// File: rtl/eq_mac_scheduler.sv
// eq_mac_scheduler: round-robin owner of the shared FIR MAC; sequences clear, TAPS accumulates and a done pulse per band.
module eq_mac_scheduler #(
    parameter int NUM_BANDS = 5,
    parameter int TAPS      = 1021,
    parameter int ADDR_W    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BANDS-1:0] req,
    output logic [NUM_BANDS-1:0] gnt,
    output logic [2:0]           band_sel,
    output logic                 mac_clr,
    output logic                 mac_en,
    output logic [ADDR_W-1:0]    tap_addr,
    output logic [NUM_BANDS-1:0] done,
    output logic                 abort,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;
    localparam logic [NUM_BANDS-1:0] ONE  = NUM_BANDS'(1);
    localparam logic [ADDR_W-1:0]    LAST = ADDR_W'(TAPS - 1);
    state_t state, state_nxt;
    logic [2:0] rr_ptr, rr_nxt, pick, idx, band_sel_nxt;
    logic [3:0] sum;
    logic [NUM_BANDS-1:0] gnt_nxt, done_nxt;
    logic [ADDR_W-1:0] tap_nxt;
    logic mac_clr_nxt, mac_en_nxt, abort_nxt;
    always_comb begin
        pick = rr_ptr;
        sum  = '0;
        idx  = '0;
        for (int i = NUM_BANDS - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + 4'(i);
            idx = (sum >= 4'(NUM_BANDS)) ? 3'(sum - 4'(NUM_BANDS)) : sum[2:0];
            if (req[idx]) pick = idx;
        end
    end
    // Owner dropping req in CLR/RUN cancels the burst; rr_ptr only advances on completion.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        band_sel_nxt = band_sel;
        mac_clr_nxt  = 1'b0;
        mac_en_nxt   = mac_en;
        tap_nxt      = tap_addr;
        done_nxt     = '0;
        abort_nxt    = 1'b0;
        rr_nxt       = rr_ptr;
        case (state)
            IDLE: if (|req) begin
                state_nxt    = CLR;
                gnt_nxt      = ONE << pick;
                band_sel_nxt = pick;
                mac_clr_nxt  = 1'b1;
            end
            CLR, RUN: if (!req[band_sel]) begin
                state_nxt  = IDLE;
                gnt_nxt    = '0;
                mac_en_nxt = 1'b0;
                tap_nxt    = '0;
                abort_nxt  = 1'b1;
            end else if (state == CLR) begin
                state_nxt  = RUN;
                mac_en_nxt = 1'b1;
                tap_nxt    = '0;
            end else if (tap_addr == LAST) begin
                state_nxt  = DONE;
                mac_en_nxt = 1'b0;
                tap_nxt    = '0;
                done_nxt   = gnt;
                gnt_nxt    = '0;
                rr_nxt     = (band_sel == 3'(NUM_BANDS - 1)) ? 3'd0 : band_sel + 3'd1;
            end else begin
                tap_nxt = tap_addr + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            band_sel <= '0;
            mac_clr  <= 1'b0;
            mac_en   <= 1'b0;
            tap_addr <= '0;
            done     <= '0;
            abort    <= 1'b0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            band_sel <= band_sel_nxt;
            mac_clr  <= mac_clr_nxt;
            mac_en   <= mac_en_nxt;
            tap_addr <= tap_nxt;
            done     <= done_nxt;
            abort    <= abort_nxt;
            busy     <= (state_nxt != IDLE);
            rr_ptr   <= rr_nxt;
        end
    end
endmodule

// File: tb/tb_eq_mac_scheduler.sv
// tb_eq_mac_scheduler: directed and random checks of the MAC scheduler with a grant-order scoreboard.
module tb_eq_mac_scheduler;
    localparam int NB = 5, TAPS = 4, AW = 3;
    logic clk = 1'b0, rst = 1'b1;
    logic [NB-1:0] req = '0;
    logic [NB-1:0] gnt, done;
    logic [2:0] band_sel;
    logic mac_clr, mac_en, abort, busy;
    logic [AW-1:0] tap_addr;
    int total = 0, bad = 0;
    int exp_q[$];
    bit sb_on = 1'b1;
    int cur = 0, en_cnt = 0, e = 0;
    int w[NB] = '{default: 0};

    eq_mac_scheduler #(.NUM_BANDS(NB), .TAPS(TAPS), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .band_sel(band_sel),
        .mac_clr(mac_clr), .mac_en(mac_en), .tap_addr(tap_addr),
        .done(done), .abort(abort), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 32'({gnt, done, band_sel, tap_addr, mac_clr, mac_en, abort, busy}), 0);
    endtask

    // Scoreboard side: pops expected grants, checks burst length, done band and starvation.
    always @(negedge clk) if (!rst) begin
        chk("onehot_gnt", 32'($onehot0(gnt)), 1);
        chk("done_abort", 32'(|done && abort), 0);
        chk("en_clr", 32'(mac_en && mac_clr), 0);
        if (mac_clr) begin
            if (sb_on) begin
                chk("grant_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("grant_band", 32'(band_sel), 32'(e));
                    chk("grant_onehot", 32'(gnt), 32'(1 << e));
                end
            end
            cur = int'(band_sel);
            en_cnt = 0;
            w[cur] = 0;
        end
        if (mac_en) en_cnt++;
        if (|done) begin
            chk("done_band", 32'(done), 32'(1 << cur));
            chk("en_per_burst", 32'(en_cnt), TAPS);
            for (int i = 0; i < NB; i++) if (i != cur && req[i]) begin
                w[i]++;
                chk("starve", 32'(w[i] <= NB - 1), 1);
            end
        end
        for (int i = 0; i < NB; i++) if (!req[i]) w[i] = 0;
    end

    initial begin
        repeat (2) step();
        chk_zero("reset");
        rst = 1'b0;
        step();
        // single burst latency
        req = 5'b00100;
        exp_q.push_back(2);
        step();
        chk("t1_gnt", 32'(gnt), 32'h4);
        chk("t1_clr", 32'(mac_clr), 1);
        chk("t1_busy", 32'(busy), 1);
        for (int c = 0; c < TAPS; c++) begin
            step();
            chk("t1_en", 32'(mac_en), 1);
            chk("t1_tap", 32'(tap_addr), c);
        end
        step();
        chk("t1_done", 32'(done), 32'h4);
        chk("t1_en_off", 32'(mac_en), 0);
        req = '0;
        step();
        chk("t1_idle", 32'(busy), 0);
        // full rotation from rr_ptr=0
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        req = '1;
        for (int g = 0; g < 6; g++) exp_q.push_back(g % NB);
        for (int g = 0; g < 6; g++) begin
            if (g != 0) repeat (TAPS + 3) step();
            else step();
            chk("t2_gnt", 32'(gnt), 32'(1 << (g % NB)));
        end
        req = 5'b00001;
        repeat (TAPS + 1) step();
        chk("t2_done", 32'(done), 1);
        req = '0;
        step();
        // wrap from rr_ptr=4
        req = 5'b01000;
        exp_q.push_back(3);
        step();
        chk("t3_gnt3", 32'(gnt), 32'h8);
        repeat (TAPS + 1) step();
        chk("t3_done3", 32'(done), 32'h8);
        req = 5'b00011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        repeat (2) step();
        chk("t3_wrap", 32'(gnt), 1);
        repeat (TAPS + 3) step();
        chk("t3_next", 32'(gnt), 2);
        req = 5'b00010;
        repeat (TAPS + 1) step();
        chk("t3_done1", 32'(done), 2);
        req = '0;
        step();
        // abort keeps priority
        req = 5'b00100;
        exp_q.push_back(2);
        step();
        chk("t4_gnt", 32'(gnt), 32'h4);
        repeat (2) step();
        chk("t4_tap1", 32'(tap_addr), 1);
        req = '0;
        step();
        chk("t4_abort", 32'(abort), 1);
        chk("t4_gnt0", 32'(gnt), 0);
        chk("t4_nodone", 32'(done), 0);
        chk("t4_en0", 32'(mac_en), 0);
        req = 5'b01100;
        exp_q.push_back(2);
        exp_q.push_back(3);
        step();
        chk("t4_regrant", 32'(gnt), 32'h4);
        chk("t4_abort0", 32'(abort), 0);
        repeat (TAPS + 1) step();
        chk("t4_done2", 32'(done), 32'h4);
        repeat (2) step();
        chk("t4_gnt3", 32'(gnt), 32'h8);
        req = 5'b01000;
        repeat (TAPS + 1) step();
        chk("t4_done3", 32'(done), 32'h8);
        req = '0;
        step();
        // async reset mid-burst
        req = 5'b00001;
        exp_q.push_back(0);
        step();
        chk("t5_gnt", 32'(gnt), 1);
        repeat (3) step();
        chk("t5_tap2", 32'(tap_addr), 2);
        rst = 1'b1;
        #1;
        chk_zero("t5_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(0);
        step();
        chk("t5_regnt", 32'(gnt), 1);
        repeat (TAPS + 1) step();
        chk("t5_done", 32'(done), 1);
        req = '0;
        step();
        chk("queue_drained", 32'(exp_q.size()), 0);
        // random traffic, invariants checked by the monitor
        sb_on = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < NB; i++)
                if (gnt[i] ? ($urandom_range(63) == 0) : ($urandom_range(7) == 0)) req[i] = ~req[i];
            step();
        end
        req = '0;
        for (int n = 0; n < 20 && busy; n++) step();
        chk("final_idle", 32'(busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
